fp16_addsub_ctrl: RTL and testbench



---
 rtl/fp16_addsub_ctrl_pkg.sv | 37 +++
 rtl/fp16_addsub_ctrl_ripple_add.sv | 22 ++
 rtl/fp16_addsub_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fp16_addsub_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fp16_addsub_ctrl_pkg.sv
// Shared FP16 field widths, constants, FSM state type and operand classifiers
// for the half-precision add/subtract sequencer.
package fp16_pkg;

    localparam int unsigned EXP_W = 5;
    localparam int unsigned MAN_W = 10;
    localparam int unsigned SIG_W = 13;

    localparam logic [15:0]      QNAN    = 16'h7E00;
    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } state_e;

    // Magnitude-only classifiers: the sign bit never matters here.
    function automatic logic is_nan(input logic [14:0] mag);
        return (mag[14:10] == EXP_MAX) && (mag[9:0] != '0);
    endfunction

    function automatic logic is_inf(input logic [14:0] mag);
        return (mag[14:10] == EXP_MAX) && (mag[9:0] == '0);
    endfunction

    function automatic logic is_zero(input logic [EXP_W-1:0] e);
        return e == '0;
    endfunction

    function automatic logic [SIG_W-1:0] unpack_sig(input logic [MAN_W-1:0] m);
        return {2'b00, 1'b1, m};
    endfunction

endpackage

// File: rtl/fp16_addsub_ctrl_ripple_add.sv
// Plain ripple-carry adder; the sequencer's single shared significand adder.
module ripple_add #(
    parameter int unsigned W = 13
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o
);

    logic c;

    always_comb begin
        sum_o = '0;
        c     = cin_i;
        for (int unsigned i = 0; i < W; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
    end

endmodule

// File: rtl/fp16_addsub_ctrl.sv
// Multi-cycle FP16 add/subtract: unpack/swap, 1-bit/cycle alignment, one adder
// pass, iterative normalisation. Truncating, subnormals flushed to zero.
module fp16_addsub_ctrl
    import fp16_pkg::*;
#(
    parameter int unsigned MAX_ALIGN = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        ovf,
    output logic        unf,
    output logic        inv
);

    localparam logic [EXP_W-1:0] CAP = EXP_W'(MAX_ALIGN);

    state_e             state_q, state_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [SIG_W-1:0]   big_q, big_d;
    logic [SIG_W-1:0]   small_q, small_d;
    logic [SIG_W-1:0]   sum_q, sum_d;
    logic               sign_q, sign_d;
    logic               eff_q, eff_d;
    logic [15:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               inv_q, inv_d;

    logic               sa, sbe, eff_in, a_ge;
    logic [EXP_W-1:0]   e_big, e_small, d;
    logic [SIG_W-1:0]   sig_big, sig_small;
    logic [SIG_W-1:0]   add_b, add_sum;
    logic [EXP_W-1:0]   exp_inc, exp_dec;

    // B's sign is flipped for subtraction so everything downstream is an add.
    always_comb begin
        sa        = a[15];
        sbe       = b[15] ^ sub;
        eff_in    = sa ^ sbe;
        a_ge      = a[14:0] >= b[14:0];
        e_big     = a_ge ? a[14:10] : b[14:10];
        e_small   = a_ge ? b[14:10] : a[14:10];
        d         = e_big - e_small;
        sig_big   = unpack_sig(a_ge ? a[9:0] : b[9:0]);
        sig_small = unpack_sig(a_ge ? b[9:0] : a[9:0]);
    end

    assign add_b   = eff_q ? ~small_q : small_q;
    assign exp_inc = exp_q + 5'd1;
    assign exp_dec = exp_q - 5'd1;

    ripple_add #(.W(SIG_W)) u_add (
        .a_i   (big_q),
        .b_i   (add_b),
        .cin_i (eff_q),
        .sum_o (add_sum)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        big_d    = big_q;
        small_d  = small_q;
        sum_d    = sum_q;
        sign_d   = sign_q;
        eff_d    = eff_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inv_d    = inv_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    inv_d = 1'b0;
                    state_d = S_DONE;
                    if (is_nan(a[14:0]) || is_nan(b[14:0]) ||
                        (is_inf(a[14:0]) && is_inf(b[14:0]) && eff_in)) begin
                        result_d = QNAN;
                        inv_d    = 1'b1;
                    end else if (is_inf(a[14:0])) begin
                        result_d = a;
                    end else if (is_inf(b[14:0])) begin
                        result_d = {sbe, b[14:0]};
                    end else if (is_zero(a[14:10]) && is_zero(b[14:10])) begin
                        result_d = {sa & sbe, 15'h0000};
                    end else if (is_zero(a[14:10])) begin
                        result_d = {sbe, b[14:0]};
                    end else if (is_zero(b[14:10])) begin
                        result_d = a;
                    end else begin
                        big_d   = sig_big;
                        small_d = (d >= CAP) ? '0 : sig_small;
                        cnt_d   = (d >= CAP) ? CAP : d;
                        exp_d   = e_big;
                        sign_d  = a_ge ? sa : sbe;
                        eff_d   = eff_in;
                        state_d = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (cnt_q != '0) begin
                    small_d = small_q >> 1;
                    cnt_d   = cnt_q - 5'd1;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                sum_d   = add_sum;
                state_d = S_NORM;
            end
            S_NORM: begin
                if (sum_q == '0) begin
                    result_d = '0;
                    state_d  = S_DONE;
                end else if (sum_q[11]) begin
                    if (exp_inc == EXP_MAX) begin
                        result_d = {sign_q, EXP_MAX, 10'h000};
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_inc, sum_q[10:1]};
                    end
                    exp_d   = exp_inc;
                    state_d = S_DONE;
                end else if (sum_q[10]) begin
                    result_d = {sign_q, exp_q, sum_q[9:0]};
                    state_d  = S_DONE;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_dec;
                    if (exp_dec == '0) begin
                        result_d = {sign_q, 15'h0000};
                        unf_d    = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            exp_q    <= '0;
            big_q    <= '0;
            small_q  <= '0;
            sum_q    <= '0;
            sign_q   <= 1'b0;
            eff_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            big_q    <= big_d;
            small_q  <= small_d;
            sum_q    <= sum_d;
            sign_q   <= sign_d;
            eff_q    <= eff_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inv_q    <= inv_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign inv       = inv_q;

endmodule

// File: tb/tb_fp16_addsub_ctrl.sv
// Bench for fp16_addsub_ctrl: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_fp16_addsub_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        ovf, unf, inv;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp16_addsub_ctrl #(.MAX_ALIGN(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf),
        .inv       (inv)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference: real-number add of the two unpacked values with truncation,
    // then derive the cycle count from the shift distances.
    function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic s,
                                  output logic [15:0] r, output logic [2:0] fl, output int lat);
        int ex, ey, mx, my, bs, ss, eb, es, dd, sum, e, nl;
        logic sx, sy, sg, eff, nx, ny, ix, iy, zx, zy;
        sx = x[15]; sy = y[15] ^ s;
        ex = int'(x[14:10]); ey = int'(y[14:10]);
        mx = int'(x[9:0]);   my = int'(y[9:0]);
        nx = (ex == 31) && (mx != 0); ny = (ey == 31) && (my != 0);
        ix = (ex == 31) && (mx == 0); iy = (ey == 31) && (my == 0);
        zx = (ex == 0); zy = (ey == 0);
        eff = sx ^ sy;
        fl = 3'b000; lat = 1; r = 16'h0000;
        if (nx || ny || (ix && iy && eff)) begin
            r = 16'h7E00; fl = 3'b001;
        end else if (ix) r = x;
        else if (iy) r = {sy, y[14:0]};
        else if (zx && zy) r = {sx & sy, 15'h0000};
        else if (zx) r = {sy, y[14:0]};
        else if (zy) r = x;
        else begin
            if (ex * 1024 + mx >= ey * 1024 + my) begin
                bs = 1024 + mx; eb = ex; ss = 1024 + my; es = ey; sg = sx;
            end else begin
                bs = 1024 + my; eb = ey; ss = 1024 + mx; es = ex; sg = sy;
            end
            dd = eb - es;
            ss = (dd >= 12) ? 0 : (ss >> dd);
            sum = eff ? bs - ss : bs + ss;
            e = eb; nl = 0;
            if (sum == 0) r = 16'h0000;
            else if (sum >= 2048) begin
                e++;
                if (e == 31) begin r = {sg, 5'h1F, 10'h000}; fl = 3'b100; end
                else r = {sg, 5'(e), 10'((sum >> 1) & 1023)};
            end else begin
                while (sum < 1024) begin
                    sum = sum * 2; e--; nl++;
                    if (e == 0) break;
                end
                if (e == 0) begin r = {sg, 15'h0000}; fl = 3'b010; end
                else r = {sg, 5'(e), 10'(sum - 1024)};
            end
            // An underflow stop happens on the last shift cycle itself.
            lat = ((dd < 12) ? dd : 12) + 3 + nl + (fl[1] ? 0 : 1);
        end
    endfunction

    logic        pending = 1'b0;
    int          cyc;
    logic [15:0] m_res;
    logic [2:0]  m_fl;
    int          m_lat;

    always @(negedge clk) begin
        if (rst) begin
            pending = 1'b0;
        end else begin
            check("in_ready", {31'b0, in_ready}, {31'b0, !pending});
            if (!pending) begin
                check("out_valid_idle", {31'b0, out_valid}, 32'd0);
                if (in_valid && in_ready) begin
                    model(a, b, sub, m_res, m_fl, m_lat);
                    pending = 1'b1;
                    cyc = 0;
                end
            end else begin
                cyc++;
                check("out_valid", {31'b0, out_valid}, {31'b0, cyc >= m_lat});
                if (out_valid) begin
                    check("result", {16'b0, result}, {16'b0, m_res});
                    check("flags", {29'b0, ovf, unf, inv}, {29'b0, m_fl});
                    if (out_ready) pending = 1'b0;
                end
            end
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic ts,
                          input logic [15:0] lr, input logic [2:0] lf, input int ll, input int hold);
        int  lat;
        bit  got;
        @(posedge clk); #1;
        a = ta; b = tbv; sub = ts; in_valid = 1'b1; out_ready = (hold == 0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1; break; end
        end
        check("accept_timeout", {31'b0, got}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin got = 1; break; end
        end
        check("done_timeout", {31'b0, got}, 32'd1);
        if (got) begin
            check("lit_latency", lat, ll);
            check("lit_result", {16'b0, result}, {16'b0, lr});
            check("lit_flags", {29'b0, ovf, unf, inv}, {29'b0, lf});
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_in_ready", {31'b0, in_ready}, 32'd0);
                check("hold_result", {16'b0, result}, {16'b0, lr});
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("released", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", {16'b0, result}, 32'd0);
        check("rst_flags", {29'b0, ovf, unf, inv}, 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;

        run_op(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000,  4, 0);
        run_op(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000,  4, 0);
        run_op(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b100,  4, 5);
        run_op(16'h3C00, 16'h0C00, 1'b0, 16'h3C00, 3'b000, 16, 0);
        run_op(16'h3C00, 16'h3BFF, 1'b1, 16'h1400, 3'b000, 15, 0);
        run_op(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b001,  1, 0);
        run_op(16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 3'b001,  1, 0);
        run_op(16'h7C00, 16'hFC00, 1'b1, 16'h7C00, 3'b000,  1, 0);
        run_op(16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 3'b000,  1, 0);
        run_op(16'h0400, 16'h0000, 1'b0, 16'h0400, 3'b000,  1, 0);
        run_op(16'h0000, 16'h3C00, 1'b1, 16'hBC00, 3'b000,  1, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000,  1, 0);
        run_op(16'h4000, 16'hC200, 1'b0, 16'hBC00, 3'b000,  5, 0);
        run_op(16'h3C00, 16'h3800, 1'b0, 16'h3E00, 3'b000,  5, 0);
        run_op(16'h0800, 16'h07FF, 1'b1, 16'h0000, 3'b010,  6, 0);

        // Abort an operation mid-alignment with an asynchronous reset.
        @(posedge clk); #1;
        a = 16'h3C00; b = 16'h0C00; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_result", {16'b0, result}, 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        run_op(16'h4000, 16'hC200, 1'b0, 16'hBC00, 3'b000, 5, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
